// File: rtl/vec_mag.sv
// rtl/vec_mag.sv - fixed-point vector magnitude via serial squarer and an external sqrt responder.
// Build option: define VEC_MAG_SAT_EN to saturate the radicand on overflow instead of wrapping.
module vec_mag #(
  parameter int WIDTH = 32,
  parameter int FBITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] vx,
  input  logic [WIDTH-1:0] vy,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] mag,
  output logic             ovf,
  output logic             sqrt_start,
  output logic [WIDTH-1:0] sqrt_rad,
  input  logic             sqrt_done,
  input  logic [WIDTH-1:0] sqrt_root
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ABS       = 3'd1;
  localparam logic [2:0] S_MUL_X     = 3'd2;
  localparam logic [2:0] S_MUL_Y     = 3'd3;
  localparam logic [2:0] S_SUM       = 3'd4;
  localparam logic [2:0] S_SQRT_REQ  = 3'd5;
  localparam logic [2:0] S_SQRT_WAIT = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

`ifdef VEC_MAG_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic [2:0]         state_q, state_d;
  logic [WIDTH-1:0]   vx_q, vx_d, vy_q, vy_d;
  logic [WIDTH-1:0]   ay_q, ay_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      bit_q, bit_d;
  logic [WIDTH-1:0]   sqx_q, sqx_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [WIDTH-1:0]   rad_q, rad_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic               ovf_q, ovf_d;

  logic [2*WIDTH-1:0] prod;
  logic               sq_hi_nz;
  logic [WIDTH-1:0]   sq_lo;
  logic [WIDTH:0]     sum_w;
  logic               sum_ovf;
  logic               last_bit;
  logic [WIDTH-1:0]   ax;

  // The most negative value has no positive twin, so it clamps to the largest positive one.
  function automatic logic [WIDTH-1:0] sat_abs(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v == {1'b1, {(WIDTH-1){1'b0}}})
      r = {1'b0, {(WIDTH-1){1'b1}}};
    else if (v[WIDTH-1])
      r = -v;
    else
      r = v;
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    vx_d       = vx_q;
    vy_d       = vy_q;
    ay_d       = ay_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    bit_d      = bit_q;
    sqx_d      = sqx_q;
    ovf_pend_d = ovf_pend_q;
    rad_d      = rad_q;
    mag_d      = mag_q;
    ovf_d      = ovf_q;

    prod     = acc_q + (mplier_q[0] ? mcand_q : '0);
    sq_hi_nz = |prod[2*WIDTH-1:WIDTH+FBITS];
    sq_lo    = prod[WIDTH+FBITS-1:FBITS];
    sum_w    = {1'b0, sqx_q} + {1'b0, acc_q[WIDTH+FBITS-1:FBITS]};
    sum_ovf  = ovf_pend_q | sum_w[WIDTH];
    last_bit = (bit_q == CW'(WIDTH-1));
    ax       = sat_abs(vx_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          vx_d    = vx;
          vy_d    = vy;
          state_d = S_ABS;
        end
      end
      S_ABS: begin
        mcand_d    = {{WIDTH{1'b0}}, ax};
        mplier_d   = ax;
        ay_d       = sat_abs(vy_q);
        acc_d      = '0;
        bit_d      = '0;
        ovf_pend_d = 1'b0;
        state_d    = S_MUL_X;
      end
      S_MUL_X: begin
        acc_d    = prod;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        bit_d    = bit_q + 1'b1;
        if (last_bit) begin
          // Park the x square and reload the shared accumulator for y.
          sqx_d      = sq_lo;
          ovf_pend_d = sq_hi_nz;
          acc_d      = '0;
          mcand_d    = {{WIDTH{1'b0}}, ay_q};
          mplier_d   = ay_q;
          bit_d      = '0;
          state_d    = S_MUL_Y;
        end
      end
      S_MUL_Y: begin
        acc_d    = prod;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        bit_d    = bit_q + 1'b1;
        if (last_bit) begin
          ovf_pend_d = ovf_pend_q | sq_hi_nz;
          state_d    = S_SUM;
        end
      end
      S_SUM: begin
        rad_d      = (sum_ovf && SAT_EN) ? {WIDTH{1'b1}} : sum_w[WIDTH-1:0];
        ovf_pend_d = sum_ovf;
        acc_d      = '0;
        state_d    = S_SQRT_REQ;
      end
      S_SQRT_REQ: begin
        state_d = S_SQRT_WAIT;
      end
      S_SQRT_WAIT: begin
        if (sqrt_done) begin
          mag_d   = sqrt_root;
          ovf_d   = ovf_pend_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      vx_q       <= '0;
      vy_q       <= '0;
      ay_q       <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      bit_q      <= '0;
      sqx_q      <= '0;
      ovf_pend_q <= 1'b0;
      rad_q      <= '0;
      mag_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      vx_q       <= vx_d;
      vy_q       <= vy_d;
      ay_q       <= ay_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      bit_q      <= bit_d;
      sqx_q      <= sqx_d;
      ovf_pend_q <= ovf_pend_d;
      rad_q      <= rad_d;
      mag_q      <= mag_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign sqrt_start = (state_q == S_SQRT_REQ);
  assign sqrt_rad   = rad_q;
  assign mag        = mag_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_vec_mag.sv
// tb/tb_vec_mag.sv - directed scoreboard bench for vec_mag with a 16-cycle behavioural sqrt responder.
module tb_vec_mag;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] vx, vy;
  logic        busy, done, ovf, sqrt_start;
  logic [31:0] mag, sqrt_rad, sqrt_root;
  logic        sd_resp, stray_sd;
  wire         sqrt_done = sd_resp | stray_sd;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [31:0] rad;
    logic [31:0] mag;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  vec_mag dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .vx        (vx),
    .vy        (vy),
    .busy      (busy),
    .done      (done),
    .mag       (mag),
    .ovf       (ovf),
    .sqrt_start(sqrt_start),
    .sqrt_rad  (sqrt_rad),
    .sqrt_done (sqrt_done),
    .sqrt_root (sqrt_root)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] isqrt(input logic [63:0] n);
    logic [63:0] r, t;
    r = 64'd0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= n) r = t;
    end
    return r[31:0];
  endfunction

  // Reference radicand and overflow flag, built from plain multiplication.
  function automatic logic [32:0] ref_rad(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] axv, ayv;
    logic [63:0] sx, sy;
    logic [32:0] s;
    logic        o;
    axv = (x == 32'h8000_0000) ? 32'h7FFF_FFFF : (x[31] ? -x : x);
    ayv = (y == 32'h8000_0000) ? 32'h7FFF_FFFF : (y[31] ? -y : y);
    sx  = ({32'd0, axv} * {32'd0, axv}) >> 16;
    sy  = ({32'd0, ayv} * {32'd0, ayv}) >> 16;
    o   = (sx[63:32] != 32'd0) || (sy[63:32] != 32'd0);
    s   = {1'b0, sx[31:0]} + {1'b0, sy[31:0]};
    o   = o | s[32];
`ifdef VEC_MAG_SAT_EN
    return {o, o ? 32'hFFFF_FFFF : s[31:0]};
`else
    return {o, s[31:0]};
`endif
  endfunction

  initial begin
    logic [31:0] r_rad;
    sd_resp   = 1'b0;
    sqrt_root = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (sqrt_start && !rst) begin
        r_rad = sqrt_rad;
        repeat (16) begin @(posedge clk); #1; end
        sqrt_root = isqrt({16'd0, r_rad, 16'd0});
        sd_resp   = 1'b1;
        @(posedge clk); #1;
        sd_resp   = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] erad, input logic [31:0] emag,
                        input logic eovf, input int repulse_at);
    exp_t        e;
    int          acc_cyc, ss_cyc, sd_cyc, done_cyc;
    logic [31:0] rad_hold;
    logic        rad_stable;
    sb.push_back('{rad: erad, mag: emag, ovf: eovf});
    @(negedge clk);
    start = 1'b1; vx = x; vy = y; acc_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    ss_cyc = -1; sd_cyc = -1; done_cyc = -1;
    rad_hold = 32'd0; rad_stable = 1'b1;
    for (int k = 0; k < 400 && done_cyc < 0; k++) begin
      if (repulse_at > 0 && cyc == acc_cyc + repulse_at) begin
        start = 1'b1; vx = 32'h0007_0000; vy = 32'h0009_0000;
      end else begin
        start = 1'b0;
      end
      if (sqrt_start) begin
        ss_cyc = cyc; rad_hold = sqrt_rad;
      end else if (ss_cyc >= 0 && sqrt_rad !== rad_hold) begin
        rad_stable = 1'b0;
      end
      if (sqrt_done && ss_cyc >= 0) sd_cyc = cyc;
      if (done) done_cyc = cyc;
      else @(negedge clk);
    end
    start = 1'b0;
    e = sb.pop_front();
    check("done_seen", 64'(done_cyc >= 0), 64'd1);
    check("sqrt_start_latency", 64'(ss_cyc - acc_cyc), 64'd67);
    check("sqrt_rad", {32'd0, rad_hold}, {32'd0, e.rad});
    check("sqrt_rad_stable", {63'd0, rad_stable}, 64'd1);
    check("done_after_sqrt_done", 64'(done_cyc - sd_cyc), 64'd1);
    check("mag", {32'd0, mag}, {32'd0, e.mag});
    check("ovf", {63'd0, ovf}, {63'd0, e.ovf});
    @(negedge clk);
    check("done_one_cycle", {62'd0, done, busy}, 64'd0);
    check("mag_hold", {31'd0, ovf, mag}, {31'd0, e.ovf, e.mag});
  endtask

  initial begin
    logic [32:0] rr;
    logic [31:0] big_rad;
    int          hits;
    rst = 1'b1; start = 1'b0; vx = 32'd0; vy = 32'd0; stray_sd = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_sqrt_start", {63'd0, sqrt_start}, 64'd0);
    check("rst_mag", {32'd0, mag}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    check("rst_sqrt_rad", {32'd0, sqrt_rad}, 64'd0);
    rst = 1'b0;

    run_op(32'h0003_0000, 32'h0004_0000, 32'h0019_0000, 32'h0005_0000, 1'b0, 0);
    run_op(32'hFFFD_0000, 32'h0004_0000, 32'h0019_0000, 32'h0005_0000, 1'b0, 0);
    run_op(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 0);

`ifdef VEC_MAG_SAT_EN
    big_rad = 32'hFFFF_FFFF;
`else
    big_rad = 32'h3880_0000;
`endif
    run_op(32'h00C8_0000, 32'h00C8_0000, big_rad, isqrt({16'd0, big_rad, 16'd0}), 1'b1, 0);
    run_op(32'h0003_0000, 32'h0004_0000, 32'h0019_0000, 32'h0005_0000, 1'b0, 0);

    rr = ref_rad(32'h8000_0000, 32'h0000_0000);
    run_op(32'h8000_0000, 32'h0000_0000, rr[31:0], isqrt({16'd0, rr[31:0], 16'd0}), rr[32], 0);

    // Second start lands in MUL_Y and must be ignored.
    run_op(32'h0003_0000, 32'h0004_0000, 32'h0019_0000, 32'h0005_0000, 1'b0, 40);

    @(negedge clk); stray_sd = 1'b1;
    @(negedge clk); stray_sd = 1'b0;
    check("stray_sqrt_done_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("stray_sqrt_done_done", {63'd0, done}, 64'd0);

    @(negedge clk); start = 1'b1; vx = 32'h0003_0000; vy = 32'h0004_0000;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_mag", {32'd0, mag}, 64'd0);
    hits = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sqrt_start || done) hits++;
    end
    check("abort_no_sqrt_start_no_done", 64'(hits), 64'd0);
    run_op(32'h0003_0000, 32'h0004_0000, 32'h0019_0000, 32'h0005_0000, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vec_mag.md
VEC_MAG -- requirements
Module: vec_mag

Interface
REQ-001 WIDTH, 32, total bits of every fixed-point operand and result.
REQ-002 FBITS, 16, fraction bits (Q16.16 at defaults).
REQ-003 One clock, clk. Reset rst is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  request a magnitude computation; sampled only in IDLE.
REQ-007 vx, vy  in  WIDTH each  signed two's-complement vector components, captured on start accept.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse; mag and ovf valid from this cycle on.
REQ-010 mag  out  WIDTH  unsigned magnitude sqrt(vx^2+vy^2), same FBITS.
REQ-011 ovf  out  1  sum of squares exceeded WIDTH bits; valid with done.
REQ-012 sqrt_start  out  1  one-cycle request pulse to the external sqrt responder.
REQ-013 sqrt_rad  out  WIDTH  radicand; held stable from sqrt_start until sqrt_done.
REQ-014 sqrt_done  in  1  responder result valid.
REQ-015 sqrt_root  in  WIDTH  responder root, sampled when sqrt_done is high.

Function
REQ-016 States: IDLE, ABS, MUL_X, MUL_Y, SUM, SQRT_REQ, SQRT_WAIT, DONE.
REQ-017 IDLE->ABS when start=1; vx, vy registered that cycle.
REQ-018 ABS (1 cycle): absolute values; most-negative input saturates to 2^(WIDTH-1)-1.
REQ-019 MUL_X then MUL_Y: shift-add squarer, one multiplier bit per cycle, exactly WIDTH cycles each, one shared 2*WIDTH-bit accumulator.
REQ-020 Each square is the 2*WIDTH product shifted right FBITS; nonzero bits above WIDTH after the shift set the overflow condition.
REQ-021 SUM (1 cycle): WIDTH-bit add of both squares; a carry out sets the overflow condition; result drives sqrt_rad.
REQ-022 SQRT_REQ (1 cycle): sqrt_start=1; sqrt_start asserts exactly 2*WIDTH+3 cycles after start accept.
REQ-023 SQRT_WAIT: holds until sqrt_done=1, with no timeout; the cycle sqrt_done is sampled high, sqrt_root is captured into mag.
REQ-024 DONE (1 cycle): done=1, then IDLE.
REQ-025 mag and ovf hold their values until the next done.
REQ-026 start is ignored while busy=1. sqrt_done is ignored outside SQRT_WAIT.
REQ-027 start held high continuously starts a new computation on each return to IDLE.

Reset
REQ-028 rst forces IDLE in any state, including mid-multiply and SQRT_WAIT.
REQ-029 Reset values: busy=0, done=0, sqrt_start=0, mag=0, ovf=0, sqrt_rad=0, accumulator=0.
REQ-030 An operation interrupted by rst never produces done.

Configuration
REQ-031 Macro VEC_MAG_SAT_EN defined: on the overflow condition, sqrt_rad = all ones (2^WIDTH-1) and ovf=1.
REQ-032 VEC_MAG_SAT_EN undefined: on the overflow condition, sqrt_rad = low WIDTH bits of the shifted sum (wrap) and ovf=1.
REQ-033 Both builds: no overflow gives ovf=0 and an identical sqrt_rad.

Verification (defaults; bench drives a behavioural sqrt responder with 16-cycle latency)
REQ-034 vx=0x0003_0000, vy=0x0004_0000, start pulse -> sqrt_start at cycle 67, sqrt_rad=0x0019_0000, done with mag=0x0005_0000, ovf=0.
REQ-035 vx=0xFFFD_0000 (-3.0), vy=0x0004_0000 -> identical sqrt_rad, mag and ovf to REQ-034.
REQ-036 vx=0, vy=0 -> sqrt_rad=0, mag=0, ovf=0; done one cycle after sqrt_done.
REQ-037 vx=vy=0x00C8_0000 (200.0) -> ovf=1:
- with VEC_MAG_SAT_EN: sqrt_rad=0xFFFF_FFFF.
- without VEC_MAG_SAT_EN: sqrt_rad=0x3880_0000.
REQ-038 start re-pulsed with new vx, vy during MUL_Y -> ignored; result matches the first inputs.
REQ-039 rst asserted during MUL_X -> busy=0 next cycle; no sqrt_start, no done; a following start with vx=3.0, vy=4.0 completes correctly.
